mmu_join2_sync: RTL and testbench

- Clocked two-input join for the MMU handshake fabric; the converging counterpart of the two-way drive/free fork.
- Accepts two 2-phase (transition-signalled) drive/free input channels with bundled data.
- Fires one merged output token once both inputs have a pending request. Acks both producers at capture time, so the next input pair can arrive while the output token is outstanding (1-deep buffer).
- Sits where two MMU sub-results (e.g. tag-lookup and permission-check) must be joined before the next stage.

---
 rtl/mmu_join2_sync.sv | 171 +++++++++++++++++
 tb/tb_mmu_join2_sync.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_join2_sync.sv
// mmu_join2_sync: clocked two-input 2-phase join with a 1-deep output token.
// Ports: clk, rst (sync, active-high); i_drive0/i_data0/o_free0 and
// i_drive1/i_data1/o_free1 are the input channels; o_driveNext/o_dataNext/
// i_freeNext are the merged output channel; o_err is a sticky protocol flag.
// Option: define MMU_JOIN_SYNC_EN to pass drive/free levels through
// 2-flop synchronisers (data stays unsynchronised, it is bundled).
module mmu_join2_sync #(
  parameter int W0 = 8,
  parameter int W1 = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_drive0,
  input  logic [W0-1:0]    i_data0,
  output logic             o_free0,
  input  logic             i_drive1,
  input  logic [W1-1:0]    i_data1,
  output logic             o_free1,
  output logic             o_driveNext,
  output logic [W0+W1-1:0] o_dataNext,
  input  logic             i_freeNext,
  output logic             o_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic d0;
  logic d1;
  logic fn;

`ifdef MMU_JOIN_SYNC_EN
  logic [1:0] sync0;
  logic [1:0] sync1;
  logic [1:0] syncf;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 2'b00;
      sync1 <= 2'b00;
      syncf <= 2'b00;
    end else begin
      sync0 <= {sync0[0], i_drive0};
      sync1 <= {sync1[0], i_drive1};
      syncf <= {syncf[0], i_freeNext};
    end
  end

  assign d0 = sync0[1];
  assign d1 = sync1[1];
  assign fn = syncf[1];
`else
  assign d0 = i_drive0;
  assign d1 = i_drive1;
  assign fn = i_freeNext;
`endif

  state_t state;
  state_t state_n;
  logic seen0;
  logic seen1;
  logic seen_free;
  logic prev0;
  logic prev1;

  logic seen0_n;
  logic seen1_n;
  logic seen_free_n;
  logic drive_n;
  logic free0_n;
  logic free1_n;
  logic [W0+W1-1:0] data_n;
  logic err_n;

  logic pend0;
  logic pend1;
  logic free_evt;
  logic fire;
  logic err_a;
  logic err_b;

  assign pend0    = d0 ^ seen0;
  assign pend1    = d1 ^ seen1;
  assign free_evt = fn ^ seen_free;
  assign fire     = pend0 & pend1 &
                    ((state == EMPTY) | free_evt);

  // A channel that was already pending last cycle must not move again
  // before it is acked.
  assign err_a = ((d0 != prev0) && (prev0 != seen0)) ||
                 ((d1 != prev1) && (prev1 != seen1));
  // A downstream ack with nothing outstanding.
  assign err_b = free_evt && (state == EMPTY);

  always_comb begin
    state_n     = state;
    seen0_n     = seen0;
    seen1_n     = seen1;
    seen_free_n = seen_free;
    drive_n     = o_driveNext;
    free0_n     = o_free0;
    free1_n     = o_free1;
    data_n      = o_dataNext;
    err_n       = o_err | err_a | err_b;

    unique case (state)
      EMPTY: begin
        if (fire) begin
          data_n  = {i_data1, i_data0};
          drive_n = ~o_driveNext;
          free0_n = ~o_free0;
          free1_n = ~o_free1;
          seen0_n = d0;
          seen1_n = d1;
          state_n = FULL;
        end
      end
      FULL: begin
        if (free_evt) begin
          seen_free_n = fn;
        end
        if (fire) begin
          // Ack absorbed and the next token issued on the same edge.
          data_n  = {i_data1, i_data0};
          drive_n = ~o_driveNext;
          free0_n = ~o_free0;
          free1_n = ~o_free1;
          seen0_n = d0;
          seen1_n = d1;
          state_n = FULL;
        end else if (free_evt) begin
          state_n = EMPTY;
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      seen0       <= 1'b0;
      seen1       <= 1'b0;
      seen_free   <= 1'b0;
      prev0       <= 1'b0;
      prev1       <= 1'b0;
      o_driveNext <= 1'b0;
      o_free0     <= 1'b0;
      o_free1     <= 1'b0;
      o_dataNext  <= '0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_n;
      seen0       <= seen0_n;
      seen1       <= seen1_n;
      seen_free   <= seen_free_n;
      prev0       <= d0;
      prev1       <= d1;
      o_driveNext <= drive_n;
      o_free0     <= free0_n;
      o_free1     <= free1_n;
      o_dataNext  <= data_n;
      o_err       <= err_n;
    end
  end

endmodule

// File: tb/tb_mmu_join2_sync.sv
// tb_mmu_join2_sync: directed vectors plus randomized producers/consumer
// checked against a token-counting reference model.
module tb_mmu_join2_sync;

`ifdef MMU_JOIN_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_drive0;
  logic [7:0]  i_data0;
  logic        o_free0;
  logic        i_drive1;
  logic [7:0]  i_data1;
  logic        o_free1;
  logic        o_driveNext;
  logic [15:0] o_dataNext;
  logic        i_freeNext;
  logic        o_err;

  mmu_join2_sync #(.W0(8), .W1(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_drive0   (i_drive0),
    .i_data0    (i_data0),
    .o_free0    (o_free0),
    .i_drive1   (i_drive1),
    .i_data1    (i_data1),
    .o_free1    (o_free1),
    .o_driveNext(o_driveNext),
    .o_dataNext (o_dataNext),
    .i_freeNext (i_freeNext),
    .o_err      (o_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: counts transitions per channel and tokens issued.
  bit          h0[2];
  bit          h1[2];
  bit          hf[2];
  bit          ml0, ml1, mlf;
  int          mn0, mn1, mfc;
  bit          mout;
  int          mtok;
  logic [15:0] mdata;
  bit          merr;

  task automatic model_reset();
    h0 = '{0, 0};
    h1 = '{0, 0};
    hf = '{0, 0};
    ml0 = 0; ml1 = 0; mlf = 0;
    mn0 = 0; mn1 = 0; mfc = 0;
    mout = 0; mtok = 0; mdata = '0; merr = 0;
  endtask

  task automatic model_edge();
    bit d0, d1, fn, p0, p1, fev, fire;
    if (rst) begin
      model_reset();
      return;
    end
    if (SD == 0) begin
      d0 = i_drive0; d1 = i_drive1; fn = i_freeNext;
    end else begin
      d0 = h0[1]; d1 = h1[1]; fn = hf[1];
    end
    h0[1] = h0[0]; h0[0] = i_drive0;
    h1[1] = h1[0]; h1[0] = i_drive1;
    hf[1] = hf[0]; hf[0] = i_freeNext;
    if (d0 != ml0) begin
      if (mn0 % 2 == 1) merr = 1;
      mn0++;
    end
    if (d1 != ml1) begin
      if (mn1 % 2 == 1) merr = 1;
      mn1++;
    end
    if (fn != mlf) mfc++;
    p0  = (mn0 % 2 == 1);
    p1  = (mn1 % 2 == 1);
    fev = (mfc % 2 == 1);
    if (fev && !mout) merr = 1;
    fire = p0 && p1 && (!mout || fev);
    if (fire) begin
      mn0 = 0;
      mn1 = 0;
      mtok++;
      mdata = {i_data1, i_data0};
      if (mout && fev) mfc = 0;
      mout = 1;
    end else if (mout && fev) begin
      mfc = 0;
      mout = 0;
    end
    ml0 = d0; ml1 = d1; mlf = fn;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string tag);
    bit tb;
    tb = (mtok % 2 == 1);
    chk({tag, ".drive"}, {31'd0, o_driveNext}, {31'd0, tb});
    chk({tag, ".free0"}, {31'd0, o_free0}, {31'd0, tb});
    chk({tag, ".free1"}, {31'd0, o_free1}, {31'd0, tb});
    chk({tag, ".data"}, {16'd0, o_dataNext}, {16'd0, mdata});
    chk({tag, ".err"}, {31'd0, o_err}, {31'd0, merr});
  endtask

  typedef struct {
    logic       d0;
    logic       d1;
    logic       fn;
    logic [7:0] a0;
    logic [7:0] a1;
    logic       ex_drv;
    logic       ex_fr;
    logic [15:0] ex_data;
    logic       ex_err;
  } vec_t;

  function automatic vec_t mk(logic d0, logic d1, logic fn,
                              logic [7:0] a0, logic [7:0] a1,
                              logic ed, logic ef,
                              logic [15:0] edat, logic ee);
    vec_t v;
    v.d0 = d0; v.d1 = d1; v.fn = fn;
    v.a0 = a0; v.a1 = a1;
    v.ex_drv = ed; v.ex_fr = ef;
    v.ex_data = edat; v.ex_err = ee;
    return v;
  endfunction

  vec_t tbl[9];

  bit w0, w1, lf0, lf1;

  initial begin
    tbl[0] = mk(1, 1, 0, 8'h5A, 8'hC3, 1, 1, 16'hC35A, 0);
    tbl[1] = mk(0, 0, 0, 8'h11, 8'h22, 1, 1, 16'hC35A, 0);
    tbl[2] = mk(0, 0, 1, 8'h11, 8'h22, 0, 0, 16'h2211, 0);
    tbl[3] = mk(0, 0, 1, 8'h11, 8'h22, 0, 0, 16'h2211, 0);
    tbl[4] = mk(0, 0, 0, 8'h11, 8'h22, 0, 0, 16'h2211, 0);
    tbl[5] = mk(1, 0, 0, 8'h33, 8'h22, 0, 0, 16'h2211, 0);
    tbl[6] = mk(0, 0, 0, 8'h33, 8'h22, 0, 0, 16'h2211, 1);
    tbl[7] = mk(0, 1, 0, 8'h33, 8'h44, 0, 0, 16'h2211, 1);
    tbl[8] = mk(1, 1, 0, 8'h55, 8'h44, 1, 1, 16'h4455, 1);

    model_reset();
    rst = 1'b1;
    i_drive0 = 1'b0; i_drive1 = 1'b0; i_freeNext = 1'b0;
    i_data0 = '0; i_data1 = '0;
    cycle();
    cycle();
    chk("rst.drive", {31'd0, o_driveNext}, 32'd0);
    chk("rst.free0", {31'd0, o_free0}, 32'd0);
    chk("rst.free1", {31'd0, o_free1}, 32'd0);
    chk("rst.data", {16'd0, o_dataNext}, 32'd0);
    chk("rst.err", {31'd0, o_err}, 32'd0);
    rst = 1'b0;

`ifndef MMU_JOIN_SYNC_EN
    i_drive0 = 1'b1;
    i_data0 = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("single.drive", {31'd0, o_driveNext}, 32'd0);
      chk("single.free0", {31'd0, o_free0}, 32'd0);
      chk("single.err", {31'd0, o_err}, 32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      i_drive0 = tbl[i].d0;
      i_drive1 = tbl[i].d1;
      i_freeNext = tbl[i].fn;
      i_data0 = tbl[i].a0;
      i_data1 = tbl[i].a1;
      cycle();
      chk($sformatf("vec%0d.drive", i), {31'd0, o_driveNext},
          {31'd0, tbl[i].ex_drv});
      chk($sformatf("vec%0d.free0", i), {31'd0, o_free0},
          {31'd0, tbl[i].ex_fr});
      chk($sformatf("vec%0d.free1", i), {31'd0, o_free1},
          {31'd0, tbl[i].ex_fr});
      chk($sformatf("vec%0d.data", i), {16'd0, o_dataNext},
          {16'd0, tbl[i].ex_data});
      chk($sformatf("vec%0d.err", i), {31'd0, o_err},
          {31'd0, tbl[i].ex_err});
    end

    // Reset while a token is outstanding.
    rst = 1'b1;
    i_drive0 = 1'b0; i_drive1 = 1'b0; i_freeNext = 1'b0;
    cycle();
    chk("midrst.drive", {31'd0, o_driveNext}, 32'd0);
    chk("midrst.free0", {31'd0, o_free0}, 32'd0);
    chk("midrst.free1", {31'd0, o_free1}, 32'd0);
    chk("midrst.data", {16'd0, o_dataNext}, 32'd0);
    chk("midrst.err", {31'd0, o_err}, 32'd0);
    rst = 1'b0;

    // Ack with nothing outstanding.
    i_freeNext = 1'b1;
    cycle();
    chk("spfree.err", {31'd0, o_err}, 32'd1);
    chk("spfree.drive", {31'd0, o_driveNext}, 32'd0);
    i_freeNext = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("spfree.sticky", {31'd0, o_err}, 32'd1);
      chk("spfree.hold", {31'd0, o_driveNext}, 32'd0);
    end
    rst = 1'b1;
    cycle();
    chk("spfree.clr", {31'd0, o_err}, 32'd0);
    rst = 1'b0;
`else
    // Both drives move in cycle 0; output must wait for the 3rd edge.
    i_drive0 = 1'b1; i_data0 = 8'hA1;
    i_drive1 = 1'b1; i_data1 = 8'hB2;
    cycle();
    chk("sync.e1", {31'd0, o_driveNext}, 32'd0);
    cycle();
    chk("sync.e2", {31'd0, o_driveNext}, 32'd0);
    cycle();
    chk("sync.e3", {31'd0, o_driveNext}, 32'd1);
    chk("sync.data", {16'd0, o_dataNext}, 32'h0000B2A1);
    chk("sync.free0", {31'd0, o_free0}, 32'd1);
    rst = 1'b1;
    i_drive0 = 1'b0; i_drive1 = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
`endif

    // Randomized legal traffic against the model.
    i_drive0 = 1'b0; i_drive1 = 1'b0; i_freeNext = 1'b0;
    w0 = 0; w1 = 0; lf0 = 0; lf1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (w0 && (o_free0 != lf0)) begin
        w0 = 0;
        lf0 = o_free0;
      end
      if (w1 && (o_free1 != lf1)) begin
        w1 = 0;
        lf1 = o_free1;
      end
      if (!w0 && $urandom_range(0, 2) == 0) begin
        i_drive0 = ~i_drive0;
        i_data0 = 8'($urandom);
        w0 = 1;
      end
      if (!w1 && $urandom_range(0, 2) == 0) begin
        i_drive1 = ~i_drive1;
        i_data1 = 8'($urandom);
        w1 = 1;
      end
      if ((o_driveNext != i_freeNext) && $urandom_range(0, 1) == 0)
        i_freeNext = ~i_freeNext;
      cycle();
      check_model("rand");
    end
    chk("rand.noerr", {31'd0, o_err}, 32'd0);
    if (mtok < 50) begin
      n_fail++;
      $display("FAIL rand.tokens: got %0d expected >= 50", mtok);
    end
    n_chk++;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
